rs_array: RTL and testbench

- Parametrised multi-entry reservation station built from generalised per-entry slots.
- Accepts one dispatched instruction per cycle and wakes operands from CDB_N completion broadcasts.
- Issues the oldest ready entry to the FU through a valid/ready handshake.
- Squashes or clears entries on branch resolution. Sits between the dispatch/rename stage and the FU issue stage.

---
 rtl/rs_array_if.sv | 63 ++++++
 rtl/rs_array.sv | 230 +++++++++++++++++++++++
 tb/tb_rs_array.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_array_if.sv
// rs_array_if: dispatch, CDB wakeup, issue and branch-resolution signals of a
// reservation station.
//   master: the surrounding pipeline (rename/dispatch, CDB, FU, branch unit)
//   slave : the reservation station itself
// Ports are named from the station's point of view (_i into it, _o out of it).
interface rs_array_if #(
  parameter int unsigned RS_DEPTH  = 8,
  parameter int unsigned CDB_N     = 2,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned BR_MASK_W = 4,
  parameter int unsigned FU_SEL_W  = 3
);
  localparam int unsigned CNT_W = $clog2(RS_DEPTH) + 1;

  // Dispatch
  logic                       disp_vld_i;
  logic                       disp_rdy_o;
  logic [PRF_IDX_W-1:0]       disp_opa_tag_i;
  logic [PRF_IDX_W-1:0]       disp_opb_tag_i;
  logic                       disp_opa_rdy_i;
  logic                       disp_opb_rdy_i;
  logic [PRF_IDX_W-1:0]       disp_dest_tag_i;
  logic [FU_SEL_W-1:0]        disp_fu_sel_i;
  logic [31:0]                disp_IR_i;
  logic [ROB_IDX_W-1:0]       disp_rob_idx_i;
  logic [BR_MASK_W-1:0]       disp_br_mask_i;
  // CDB broadcasts
  logic [CDB_N-1:0]           cdb_vld_i;
  logic [CDB_N*PRF_IDX_W-1:0] cdb_tag_i;
  // Issue
  logic                       iss_vld_o;
  logic                       iss_rdy_i;
  logic [PRF_IDX_W-1:0]       iss_opa_tag_o;
  logic [PRF_IDX_W-1:0]       iss_opb_tag_o;
  logic [PRF_IDX_W-1:0]       iss_dest_tag_o;
  logic [FU_SEL_W-1:0]        iss_fu_sel_o;
  logic [31:0]                iss_IR_o;
  logic [ROB_IDX_W-1:0]       iss_rob_idx_o;
  logic [BR_MASK_W-1:0]       iss_br_mask_o;
  // Branch resolution
  logic                       br_pred_correct_i;
  logic                       br_recovery_i;
  logic [BR_MASK_W-1:0]       br_tag_fix_i;
  // Occupancy
  logic [CNT_W-1:0]           free_cnt_o;

  modport master (
    output disp_vld_i, disp_opa_tag_i, disp_opb_tag_i, disp_opa_rdy_i, disp_opb_rdy_i,
           disp_dest_tag_i, disp_fu_sel_i, disp_IR_i, disp_rob_idx_i, disp_br_mask_i,
           cdb_vld_i, cdb_tag_i, iss_rdy_i, br_pred_correct_i, br_recovery_i, br_tag_fix_i,
    input  disp_rdy_o, iss_vld_o, iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o,
           iss_fu_sel_o, iss_IR_o, iss_rob_idx_o, iss_br_mask_o, free_cnt_o
  );

  modport slave (
    input  disp_vld_i, disp_opa_tag_i, disp_opb_tag_i, disp_opa_rdy_i, disp_opb_rdy_i,
           disp_dest_tag_i, disp_fu_sel_i, disp_IR_i, disp_rob_idx_i, disp_br_mask_i,
           cdb_vld_i, cdb_tag_i, iss_rdy_i, br_pred_correct_i, br_recovery_i, br_tag_fix_i,
    output disp_rdy_o, iss_vld_o, iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o,
           iss_fu_sel_o, iss_IR_o, iss_rob_idx_o, iss_br_mask_o, free_cnt_o
  );
endinterface

// File: rtl/rs_array.sv
// rs_array: multi-entry reservation station with CDB wakeup, oldest-ready
// selection through an age matrix, and branch squash/clear.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - rs_array_if.slave: dispatch in (disp_*), CDB wakeups (cdb_*),
//         issue out with valid/ready (iss_*), branch resolution (br_*),
//         registered free-entry count (free_cnt_o)
module rs_array #(
  parameter int unsigned RS_DEPTH  = 8,
  parameter int unsigned CDB_N     = 2,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned BR_MASK_W = 4,
  parameter int unsigned FU_SEL_W  = 3
) (
  input logic       clk,
  input logic       rst,
  rs_array_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  function automatic logic cdb_hit(
    input logic [PRF_IDX_W-1:0]       tag,
    input logic [CDB_N-1:0]           vld,
    input logic [CDB_N*PRF_IDX_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_N; k++) begin
      if (vld[k] && (tags[k*PRF_IDX_W +: PRF_IDX_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Entry storage
  logic [RS_DEPTH-1:0]  valid_q, valid_d;
  logic [RS_DEPTH-1:0]  opa_rdy_q, opa_rdy_d;
  logic [RS_DEPTH-1:0]  opb_rdy_q, opb_rdy_d;
  logic [PRF_IDX_W-1:0] opa_tag_q  [RS_DEPTH];
  logic [PRF_IDX_W-1:0] opa_tag_d  [RS_DEPTH];
  logic [PRF_IDX_W-1:0] opb_tag_q  [RS_DEPTH];
  logic [PRF_IDX_W-1:0] opb_tag_d  [RS_DEPTH];
  logic [PRF_IDX_W-1:0] dest_tag_q [RS_DEPTH];
  logic [PRF_IDX_W-1:0] dest_tag_d [RS_DEPTH];
  logic [FU_SEL_W-1:0]  fu_sel_q   [RS_DEPTH];
  logic [FU_SEL_W-1:0]  fu_sel_d   [RS_DEPTH];
  logic [31:0]          ir_q       [RS_DEPTH];
  logic [31:0]          ir_d       [RS_DEPTH];
  logic [ROB_IDX_W-1:0] rob_idx_q  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] rob_idx_d  [RS_DEPTH];
  logic [BR_MASK_W-1:0] br_mask_q  [RS_DEPTH];
  logic [BR_MASK_W-1:0] br_mask_d  [RS_DEPTH];
  // older_q[i][j] set: entry i was allocated before entry j
  logic [RS_DEPTH-1:0]  older_q    [RS_DEPTH];
  logic [RS_DEPTH-1:0]  older_d    [RS_DEPTH];
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

  // Per-cycle decode
  logic [RS_DEPTH-1:0]  opa_hit, opb_hit, entry_rdy, squash, sel_oh;
  logic [BR_MASK_W-1:0] clr_mask;
  logic                 disp_rdy, disp_opa_hit, disp_opb_hit, disp_drop, alloc;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_found;
  logic                 iss_vld, iss_fire;
  logic [CNT_W-1:0]     sq_cnt;

  logic [PRF_IDX_W-1:0] iss_opa_tag, iss_opb_tag, iss_dest_tag;
  logic [FU_SEL_W-1:0]  iss_fu_sel;
  logic [31:0]          iss_ir;
  logic [ROB_IDX_W-1:0] iss_rob_idx;
  logic [BR_MASK_W-1:0] iss_br_mask;

  assign clr_mask     = bus.br_pred_correct_i ? bus.br_tag_fix_i : '0;
  assign disp_rdy     = (free_cnt_q != '0);
  assign disp_opa_hit = cdb_hit(bus.disp_opa_tag_i, bus.cdb_vld_i, bus.cdb_tag_i);
  assign disp_opb_hit = cdb_hit(bus.disp_opb_tag_i, bus.cdb_vld_i, bus.cdb_tag_i);
  assign disp_drop    = bus.br_recovery_i && ((bus.disp_br_mask_i & bus.br_tag_fix_i) != '0);
  assign alloc        = bus.disp_vld_i && disp_rdy && !disp_drop;

  // Wakeup, readiness and squash; a same-cycle CDB hit counts as ready.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      opa_hit[i]   = cdb_hit(opa_tag_q[i], bus.cdb_vld_i, bus.cdb_tag_i);
      opb_hit[i]   = cdb_hit(opb_tag_q[i], bus.cdb_vld_i, bus.cdb_tag_i);
      entry_rdy[i] = valid_q[i] && (opa_rdy_q[i] || opa_hit[i]) && (opb_rdy_q[i] || opb_hit[i]);
      squash[i]    = valid_q[i] && bus.br_recovery_i && ((br_mask_q[i] & bus.br_tag_fix_i) != '0);
    end
  end

  // Oldest-ready select: entry i wins if no other ready entry is older than it.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      sel_oh[i] = entry_rdy[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if ((j != i) && entry_rdy[j] && !older_q[i][j]) sel_oh[i] = 1'b0;
      end
    end
  end

  // Issue mux; sel_oh is one-hot so an OR reduction suffices.
  always_comb begin
    iss_vld      = (entry_rdy != '0) && ((sel_oh & squash) == '0);
    iss_fire     = iss_vld && bus.iss_rdy_i;
    iss_opa_tag  = '0;
    iss_opb_tag  = '0;
    iss_dest_tag = '0;
    iss_fu_sel   = '0;
    iss_ir       = '0;
    iss_rob_idx  = '0;
    iss_br_mask  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel_oh[i] && iss_vld) begin
        iss_opa_tag  = iss_opa_tag  | opa_tag_q[i];
        iss_opb_tag  = iss_opb_tag  | opb_tag_q[i];
        iss_dest_tag = iss_dest_tag | dest_tag_q[i];
        iss_fu_sel   = iss_fu_sel   | fu_sel_q[i];
        iss_ir       = iss_ir       | ir_q[i];
        iss_rob_idx  = iss_rob_idx  | rob_idx_q[i];
        iss_br_mask  = iss_br_mask  | (br_mask_q[i] & ~clr_mask);
      end
    end
  end

  // Lowest-index free entry; entries freed this cycle are still marked valid.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    sq_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) sq_cnt = sq_cnt + CNT_W'(squash[i]);
    free_cnt_d = free_cnt_q - CNT_W'(alloc) + CNT_W'(iss_fire) + sq_cnt;
  end

  always_comb begin
    valid_d    = valid_q;
    opa_rdy_d  = opa_rdy_q;
    opb_rdy_d  = opb_rdy_q;
    opa_tag_d  = opa_tag_q;
    opb_tag_d  = opb_tag_q;
    dest_tag_d = dest_tag_q;
    fu_sel_d   = fu_sel_q;
    ir_d       = ir_q;
    rob_idx_d  = rob_idx_q;
    br_mask_d  = br_mask_q;
    older_d    = older_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i]) begin
        opa_rdy_d[i] = opa_rdy_q[i] | opa_hit[i];
        opb_rdy_d[i] = opb_rdy_q[i] | opb_hit[i];
        br_mask_d[i] = br_mask_q[i] & ~clr_mask;
        if (squash[i] || (iss_fire && sel_oh[i])) begin
          valid_d[i]   = 1'b0;
          opa_rdy_d[i] = 1'b0;
          opb_rdy_d[i] = 1'b0;
        end
      end
    end
    if (alloc) begin
      valid_d[alloc_idx]    = 1'b1;
      opa_rdy_d[alloc_idx]  = bus.disp_opa_rdy_i | disp_opa_hit;
      opb_rdy_d[alloc_idx]  = bus.disp_opb_rdy_i | disp_opb_hit;
      opa_tag_d[alloc_idx]  = bus.disp_opa_tag_i;
      opb_tag_d[alloc_idx]  = bus.disp_opb_tag_i;
      dest_tag_d[alloc_idx] = bus.disp_dest_tag_i;
      fu_sel_d[alloc_idx]   = bus.disp_fu_sel_i;
      ir_d[alloc_idx]       = bus.disp_IR_i;
      rob_idx_d[alloc_idx]  = bus.disp_rob_idx_i;
      br_mask_d[alloc_idx]  = bus.disp_br_mask_i & ~clr_mask;
      // New entry is younger than everything; stale bits of free entries are
      // rewritten when those entries are allocated later.
      for (int j = 0; j < RS_DEPTH; j++) begin
        older_d[alloc_idx][j] = 1'b0;
        older_d[j][alloc_idx] = (IDX_W'(j) != alloc_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      opa_rdy_q  <= '0;
      opb_rdy_q  <= '0;
      free_cnt_q <= CNT_W'(RS_DEPTH);
      for (int i = 0; i < RS_DEPTH; i++) begin
        opa_tag_q[i]  <= '0;
        opb_tag_q[i]  <= '0;
        dest_tag_q[i] <= '0;
        fu_sel_q[i]   <= '0;
        ir_q[i]       <= '0;
        rob_idx_q[i]  <= '0;
        br_mask_q[i]  <= '0;
        older_q[i]    <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      opa_rdy_q  <= opa_rdy_d;
      opb_rdy_q  <= opb_rdy_d;
      free_cnt_q <= free_cnt_d;
      opa_tag_q  <= opa_tag_d;
      opb_tag_q  <= opb_tag_d;
      dest_tag_q <= dest_tag_d;
      fu_sel_q   <= fu_sel_d;
      ir_q       <= ir_d;
      rob_idx_q  <= rob_idx_d;
      br_mask_q  <= br_mask_d;
      older_q    <= older_d;
    end
  end

  assign bus.disp_rdy_o     = disp_rdy;
  assign bus.free_cnt_o     = free_cnt_q;
  assign bus.iss_vld_o      = iss_vld;
  assign bus.iss_opa_tag_o  = iss_opa_tag;
  assign bus.iss_opb_tag_o  = iss_opb_tag;
  assign bus.iss_dest_tag_o = iss_dest_tag;
  assign bus.iss_fu_sel_o   = iss_fu_sel;
  assign bus.iss_IR_o       = iss_ir;
  assign bus.iss_rob_idx_o  = iss_rob_idx;
  assign bus.iss_br_mask_o  = iss_br_mask;
endmodule

// File: tb/tb_rs_array.sv
// tb_rs_array: self-checking bench for rs_array. A reference model keeps the
// station contents as an age-ordered queue (oldest first) and predicts the
// outputs every cycle.
module tb_rs_array;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CDBN  = 2;
  localparam int unsigned PW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_array_if #(.RS_DEPTH(DEPTH), .CDB_N(CDBN), .PRF_IDX_W(PW), .ROB_IDX_W(5),
                .BR_MASK_W(4), .FU_SEL_W(3)) bus ();

  rs_array #(.RS_DEPTH(DEPTH), .CDB_N(CDBN), .PRF_IDX_W(PW), .ROB_IDX_W(5),
             .BR_MASK_W(4), .FU_SEL_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [5:0]  opa;
    logic [5:0]  opb;
    logic [5:0]  dest;
    logic        ra;
    logic        rb;
    logic [2:0]  fu;
    logic [31:0] ir;
    logic [4:0]  rob;
    logic [3:0]  mask;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;

  // ---------------- reference model ----------------
  function automatic logic hit(input logic [5:0] t);
    logic h;
    h = 1'b0;
    for (int k = 0; k < CDBN; k++) begin
      if (bus.cdb_vld_i[k] && (bus.cdb_tag_i[k*PW +: PW] == t)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic int model_sel();
    int s;
    s = -1;
    for (int q = 0; q < mq.size(); q++) begin
      if (s < 0 && (mq[q].ra || hit(mq[q].opa)) && (mq[q].rb || hit(mq[q].opb))) s = q;
    end
    return s;
  endfunction

  function automatic logic model_vld(input int s);
    if (s < 0) return 1'b0;
    return !(bus.br_recovery_i && ((mq[s].mask & bus.br_tag_fix_i) != 4'b0));
  endfunction

  function automatic logic [67:0] model_snap();
    int         s;
    logic       v;
    ent_t       e;
    logic [3:0] clr;
    s   = model_sel();
    v   = model_vld(s);
    e   = '0;
    if (v) e = mq[s];
    clr = bus.br_pred_correct_i ? bus.br_tag_fix_i : 4'b0;
    return {v, (mq.size() < DEPTH), 4'(DEPTH - mq.size()), e.rob, e.ir, e.dest, e.opa, e.opb,
            e.fu, e.mask & ~clr};
  endfunction

  function automatic logic [67:0] dut_snap();
    return {bus.iss_vld_o, bus.disp_rdy_o, bus.free_cnt_o, bus.iss_rob_idx_o, bus.iss_IR_o,
            bus.iss_dest_tag_o, bus.iss_opa_tag_o, bus.iss_opb_tag_o, bus.iss_fu_sel_o,
            bus.iss_br_mask_o};
  endfunction

  // Called at the sampling point: computes the model's next contents from the
  // current inputs, then moves past the clock edge.
  task automatic advance();
    ent_t       nq[$];
    ent_t       e;
    int         s;
    logic       fire;
    logic [3:0] tag;
    s    = model_sel();
    fire = model_vld(s) && bus.iss_rdy_i;
    tag  = bus.br_tag_fix_i;
    for (int q = 0; q < mq.size(); q++) begin
      e = mq[q];
      if (!(fire && q == s) && !(bus.br_recovery_i && ((e.mask & tag) != 4'b0))) begin
        e.ra = e.ra | hit(e.opa);
        e.rb = e.rb | hit(e.opb);
        if (bus.br_pred_correct_i) e.mask = e.mask & ~tag;
        nq.push_back(e);
      end
    end
    if (bus.disp_vld_i && (mq.size() < DEPTH) &&
        !(bus.br_recovery_i && ((bus.disp_br_mask_i & tag) != 4'b0))) begin
      e.opa  = bus.disp_opa_tag_i;
      e.opb  = bus.disp_opb_tag_i;
      e.dest = bus.disp_dest_tag_i;
      e.ra   = bus.disp_opa_rdy_i | hit(bus.disp_opa_tag_i);
      e.rb   = bus.disp_opb_rdy_i | hit(bus.disp_opb_tag_i);
      e.fu   = bus.disp_fu_sel_i;
      e.ir   = bus.disp_IR_i;
      e.rob  = bus.disp_rob_idx_i;
      e.mask = bus.disp_br_mask_i & ~(bus.br_pred_correct_i ? tag : 4'b0);
      nq.push_back(e);
    end
    if (rst) nq.delete();
    @(posedge clk);
    mq = nq;
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.disp_vld_i        = 1'b0;
    bus.disp_opa_tag_i    = '0;
    bus.disp_opb_tag_i    = '0;
    bus.disp_opa_rdy_i    = 1'b0;
    bus.disp_opb_rdy_i    = 1'b0;
    bus.disp_dest_tag_i   = '0;
    bus.disp_fu_sel_i     = '0;
    bus.disp_IR_i         = '0;
    bus.disp_rob_idx_i    = '0;
    bus.disp_br_mask_i    = '0;
    bus.cdb_vld_i         = '0;
    bus.cdb_tag_i         = '0;
    bus.iss_rdy_i         = 1'b0;
    bus.br_pred_correct_i = 1'b0;
    bus.br_recovery_i     = 1'b0;
    bus.br_tag_fix_i      = '0;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [5:0] opa, input logic ra,
                      input logic [5:0] opb, input logic rb, input logic [3:0] mask);
    bus.disp_vld_i      = 1'b1;
    bus.disp_rob_idx_i  = rob;
    bus.disp_opa_tag_i  = opa;
    bus.disp_opa_rdy_i  = ra;
    bus.disp_opb_tag_i  = opb;
    bus.disp_opb_rdy_i  = rb;
    bus.disp_br_mask_i  = mask;
    bus.disp_dest_tag_i = 6'($urandom);
    bus.disp_fu_sel_i   = 3'($urandom_range(1, 7));
    bus.disp_IR_i       = $urandom;
  endtask

  task automatic cdb(input int port, input logic [5:0] tag);
    bus.cdb_vld_i[port]            = 1'b1;
    bus.cdb_tag_i[port*PW +: PW]   = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    advance();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [67:0] rst_exp;
    rst_exp = {1'b0, 1'b1, 4'd8, 62'b0};
    rst = 1'b1;
    idle();
    @(negedge clk);
    tests++;
    if (dut_snap() !== rst_exp) begin
      fails++;
      $display("FAIL reset_in dut=%h required=%h", dut_snap(), rst_exp);
    end
    advance();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_snap() !== rst_exp) begin
      fails++;
      $display("FAIL reset_out dut=%h required=%h", dut_snap(), rst_exp);
    end
    advance();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      bus.iss_rdy_i = 1'b1;
      if (c < 3) disp(5'(c), 6'(10 + c), 1'b1, 6'(20 + c), 1'b1, 4'b0);
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL inorder_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      tests++;
      if (bus.iss_vld_o !== (c >= 1 && c <= 3)) begin
        fails++;
        $display("FAIL inorder_vld c=%0d got=%b", c, bus.iss_vld_o);
      end
      if (c >= 1 && c <= 3) begin
        tests++;
        if (bus.iss_rob_idx_o !== 5'(c - 1)) begin
          fails++;
          $display("FAIL inorder_rob c=%0d got=%0d required=%0d", c, bus.iss_rob_idx_o, c - 1);
        end
      end
      if (c == 4) begin
        tests++;
        if (bus.free_cnt_o !== 4'd8) begin
          fails++;
          $display("FAIL inorder_free got=%0d required=8", bus.free_cnt_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_full_cdb();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 9) disp(5'(c), 6'd5, 1'b0, 6'(30 + c), 1'b1, 4'b0);
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL full_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      if (c >= 8) begin
        tests++;
        if (bus.disp_rdy_o !== 1'b0 || bus.free_cnt_o !== 4'd0) begin
          fails++;
          $display("FAIL full_rdy c=%0d rdy=%b free=%0d required rdy=0 free=0", c,
                   bus.disp_rdy_o, bus.free_cnt_o);
        end
      end
      advance();
    end
    // Port 1 wakes all entries; oldest issues the same cycle, then drain in order.
    for (int c = 0; c < 9; c++) begin
      idle();
      bus.iss_rdy_i = 1'b1;
      if (c == 0) cdb(1, 6'd5);
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL drain_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      tests++;
      if (c < 8 && (bus.iss_vld_o !== 1'b1 || bus.iss_rob_idx_o !== 5'(c))) begin
        fails++;
        $display("FAIL drain_order c=%0d vld=%b rob=%0d required rob=%0d", c, bus.iss_vld_o,
                 bus.iss_rob_idx_o, c);
      end else if (c == 8 && (bus.iss_vld_o !== 1'b0 || bus.free_cnt_o !== 4'd8)) begin
        fails++;
        $display("FAIL drain_end vld=%b free=%0d required vld=0 free=8", bus.iss_vld_o,
                 bus.free_cnt_o);
      end
      advance();
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      bus.iss_rdy_i = 1'b1;
      if (c == 0) begin
        disp(5'd9, 6'd7, 1'b0, 6'd12, 1'b1, 4'b0);
        cdb(0, 6'd7);
      end
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL bypass_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      tests++;
      if (bus.iss_vld_o !== (c == 1) || (c == 1 && bus.iss_rob_idx_o !== 5'd9)) begin
        fails++;
        $display("FAIL bypass_issue c=%0d vld=%b rob=%0d required vld=%0d rob=9", c,
                 bus.iss_vld_o, bus.iss_rob_idx_o, c == 1);
      end
      advance();
    end
  endtask

  task automatic test_recovery();
    logic [3:0] masks [3];
    masks[0] = 4'b0001;
    masks[1] = 4'b0010;
    masks[2] = 4'b0011;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 3) begin
        disp(5'(c), 6'd20, 1'b0, 6'd21, 1'b1, masks[c]);
      end else begin
        bus.br_recovery_i = 1'b1;
        bus.br_tag_fix_i  = 4'b0001;
        disp(5'd3, 6'd22, 1'b1, 6'd23, 1'b1, 4'b0001);
      end
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL recov_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      advance();
    end
    idle();
    bus.iss_rdy_i = 1'b1;
    cdb(0, 6'd20);
    @(negedge clk);
    tests++;
    if (bus.free_cnt_o !== 4'd7 || bus.iss_vld_o !== 1'b1 || bus.iss_rob_idx_o !== 5'd1 ||
        bus.iss_br_mask_o !== 4'b0010) begin
      fails++;
      $display("FAIL recov_survivor free=%0d vld=%b rob=%0d mask=%b required 7/1/1/0010",
               bus.free_cnt_o, bus.iss_vld_o, bus.iss_rob_idx_o, bus.iss_br_mask_o);
    end
    advance();
    idle();
    @(negedge clk);
    tests++;
    if (bus.free_cnt_o !== 4'd8 || bus.iss_vld_o !== 1'b0) begin
      fails++;
      $display("FAIL recov_empty free=%0d vld=%b required 8/0", bus.free_cnt_o, bus.iss_vld_o);
    end
    advance();
  endtask

  task automatic test_correct();
    logic [4:0] rob_exp  [4];
    logic [3:0] mask_exp [4];
    rob_exp[0] = 5'd0; mask_exp[0] = 4'b0000;
    rob_exp[1] = 5'd1; mask_exp[1] = 4'b0010;
    rob_exp[2] = 5'd2; mask_exp[2] = 4'b1000;
    rob_exp[3] = 5'd0; mask_exp[3] = 4'b0000;
    do_reset();
    idle(); disp(5'd0, 6'd1,  1'b1, 6'd2, 1'b1, 4'b0100); advance();
    idle(); disp(5'd1, 6'd30, 1'b0, 6'd3, 1'b1, 4'b0110); advance();
    idle(); disp(5'd2, 6'd30, 1'b0, 6'd4, 1'b1, 4'b1100); advance();
    for (int c = 0; c < 4; c++) begin
      idle();
      bus.iss_rdy_i = (c < 3);
      if (c == 0) begin
        bus.br_pred_correct_i = 1'b1;
        bus.br_tag_fix_i      = 4'b0100;
      end
      if (c == 1) cdb(1, 6'd30);
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL correct_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      tests++;
      if (bus.iss_vld_o !== (c < 3) || bus.iss_rob_idx_o !== rob_exp[c] ||
          bus.iss_br_mask_o !== mask_exp[c]) begin
        fails++;
        $display("FAIL correct_mask c=%0d vld=%b rob=%0d mask=%b required rob=%0d mask=%b", c,
                 bus.iss_vld_o, bus.iss_rob_idx_o, bus.iss_br_mask_o, rob_exp[c], mask_exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_hold_reset();
    do_reset();
    idle(); disp(5'd4, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0); advance();
    idle(); disp(5'd5, 6'd3, 1'b1, 6'd4, 1'b1, 4'b0); advance();
    for (int c = 0; c < 3; c++) begin
      idle();
      @(negedge clk);
      tests++;
      if (bus.iss_vld_o !== 1'b1 || bus.iss_rob_idx_o !== 5'd4 || bus.free_cnt_o !== 4'd6) begin
        fails++;
        $display("FAIL hold c=%0d vld=%b rob=%0d free=%0d required 1/4/6", c, bus.iss_vld_o,
                 bus.iss_rob_idx_o, bus.free_cnt_o);
      end
      advance();
    end
    idle();
    rst = 1'b1;
    disp(5'd6, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0);
    bus.iss_rdy_i = 1'b1;
    cdb(0, 6'd1);
    @(negedge clk);
    tests++;
    if (dut_snap() !== model_snap()) begin
      fails++;
      $display("FAIL midrst_model dut=%h model=%h", dut_snap(), model_snap());
    end
    advance();
    rst = 1'b0;
    idle();
    @(negedge clk);
    tests++;
    if (bus.free_cnt_o !== 4'd8 || bus.iss_vld_o !== 1'b0 || bus.disp_rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL midrst_clear free=%0d vld=%b rdy=%b required 8/0/1", bus.free_cnt_o,
               bus.iss_vld_o, bus.disp_rdy_o);
    end
    advance();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6) begin
        disp(5'($urandom), 6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
             6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 4'($urandom));
      end
      for (int k = 0; k < CDBN; k++) begin
        if ($urandom_range(0, 2) == 0) cdb(k, 6'($urandom_range(0, 7)));
      end
      bus.iss_rdy_i = ($urandom_range(0, 9) < 6);
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        bus.br_recovery_i = 1'b1;
        bus.br_tag_fix_i  = 4'(1 << $urandom_range(0, 3));
      end else if (r == 1) begin
        bus.br_pred_correct_i = 1'b1;
        bus.br_tag_fix_i      = 4'(1 << $urandom_range(0, 3));
      end
      rst = (c == 300);
      @(negedge clk);
      tests++;
      if (dut_snap() !== model_snap()) begin
        fails++;
        $display("FAIL random_model c=%0d dut=%h model=%h", c, dut_snap(), model_snap());
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_full_cdb();
    test_bypass();
    test_recovery();
    test_correct();
    test_hold_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
